// File: rtl/if_stage_if.sv
// Bundles the fetch-stage signals: the instruction ROM bus, the control
// inputs from later pipeline stages, and the IF/ID and EPC outputs.
// The stage itself uses the master modport; the surrounding core (or a
// testbench) uses the slave modport.
interface if_stage_if;
  // instruction ROM bus
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  // pipeline control from hazard unit, decode and execute
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq;
  logic        exc;

  // fetch state, IF/ID register and exception return address
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] epc;
  logic        epc_we;

  modport master (
    output rom_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, epc, epc_we,
    input  rom_data, stall, flush, redirect_valid, redirect_pc, irq, exc
  );

  modport slave (
    input  rom_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, epc, epc_we,
    output rom_data, stall, flush, redirect_valid, redirect_pc, irq, exc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 32-bit MIPS core.
// Owns the PC, addresses the combinational instruction ROM, and latches the
// returned word into IF/ID. It also takes the interrupt and exception vectors
// and reports the return address that the register file writes to $k0.
// PC[31] is the kernel-mode bit: sequential fetch preserves it, and a
// redirect loads the PC verbatim, so a jr $k0 can drop back to user mode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  bus
);

  // Which single update wins this edge (reset is handled in the flop block).
  typedef enum logic [2:0] {
    ACT_EXC,
    ACT_IRQ,
    ACT_REDIRECT,
    ACT_STALL,
    ACT_FETCH
  } action_e;

  logic [31:0] pc_q,            pc_d;
  logic [31:0] ifid_instr_q,    ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q,    ifid_valid_d;
  logic [31:0] epc_q,           epc_d;
  logic        epc_we_q,        epc_we_d;

  logic [31:0] pc_seq;
  logic        irq_take;
  action_e     action;

  // Sequential successor keeps the kernel bit; the low 31 bits wrap.
  assign pc_seq = {pc_q[31], pc_q[30:0] + 31'd4};

  // Interrupts are masked in kernel mode and deferred while the pipe is
  // stalled; irq is a level, so it is simply still pending afterwards.
  assign irq_take = bus.irq & ~pc_q[31] & ~bus.stall;

  // Pick the highest-priority event for this edge.
  always_comb begin
    action = ACT_FETCH;
    if (bus.exc) begin
      action = ACT_EXC;
    end else if (irq_take) begin
      action = ACT_IRQ;
    end else if (bus.redirect_valid) begin
      action = ACT_REDIRECT;
    end else if (bus.stall) begin
      action = ACT_STALL;
    end
  end

  // Next-state for PC, IF/ID and EPC according to the chosen event.
  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    epc_d           = epc_q;
    epc_we_d        = 1'b0;

    unique case (action)
      ACT_EXC: begin
        // Return to the instruction after the faulting one in decode.
        pc_d         = EXC_VEC;
        epc_d        = ifid_pc_plus4_q;
        epc_we_d     = 1'b1;
        ifid_instr_d = 32'd0;
        ifid_valid_d = 1'b0;
      end
      ACT_IRQ: begin
        // The squashed fetch (or a redirect that lost to the interrupt) is
        // where the handler's jr $k0 resumes, so nothing is dropped.
        pc_d         = IRQ_VEC;
        epc_d        = bus.redirect_valid ? bus.redirect_pc : pc_q;
        epc_we_d     = 1'b1;
        ifid_instr_d = 32'd0;
        ifid_valid_d = 1'b0;
      end
      ACT_REDIRECT: begin
        // Loaded verbatim: low address bits pass through untouched.
        pc_d         = bus.redirect_pc;
        ifid_instr_d = 32'd0;
        ifid_valid_d = 1'b0;
      end
      ACT_STALL: begin
        // PC and IF/ID hold; a flush still squashes the held instruction.
        if (bus.flush) begin
          ifid_instr_d = 32'd0;
          ifid_valid_d = 1'b0;
        end
      end
      default: begin
        pc_d = pc_seq;
        if (bus.flush) begin
          ifid_instr_d = 32'd0;
          ifid_valid_d = 1'b0;
        end else begin
          ifid_instr_d    = bus.rom_data;
          ifid_pc_plus4_d = pc_seq;
          ifid_valid_d    = 1'b1;
        end
      end
    endcase
  end

  // State registers; synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
      epc_q           <= 32'd0;
      epc_we_q        <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      epc_q           <= epc_d;
      epc_we_q        <= epc_we_d;
    end
  end

  assign bus.rom_addr      = pc_q;
  assign bus.pc            = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.epc           = epc_q;
  assign bus.epc_we        = epc_we_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver applies one set of inputs per
// cycle, predicts the post-edge state with a behavioural model and queues it;
// a monitor pops one prediction per edge and compares every output.
module tb_if_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction ROM: combinational read, word-addressed by addr[9:2].
  logic [31:0] rom [0:255];
  assign bus.rom_data = rom[bus.rom_addr[9:2]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] epc;
    logic        epc_we;
  } st_t;

  st_t m;
  st_t exp_q[$];
  bit  running = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Behavioural next state from the priority rules.
  function automatic st_t ref_next(st_t s, logic rst, logic stl, logic fl, logic rv,
                                   logic [31:0] rp, logic iq, logic ex);
    st_t n;
    logic [31:0] seq;
    n = s;
    n.epc_we = 1'b0;
    seq = (s.pc & 32'h8000_0000) | ((s.pc + 32'd4) & 32'h7FFF_FFFF);
    if (rst) begin
      n.pc = 32'h8000_0000; n.instr = 0; n.pcp4 = 0; n.valid = 0; n.epc = 0;
    end else if (ex) begin
      n.pc = 32'h8000_0008; n.epc = s.pcp4; n.epc_we = 1; n.instr = 0; n.valid = 0;
    end else if (iq && s.pc < 32'h8000_0000 && !stl) begin
      n.pc = 32'h8000_0004; n.epc = rv ? rp : s.pc; n.epc_we = 1; n.instr = 0; n.valid = 0;
    end else if (rv) begin
      n.pc = rp; n.instr = 0; n.valid = 0;
    end else if (stl) begin
      if (fl) begin n.instr = 0; n.valid = 0; end
    end else begin
      n.pc = seq;
      if (fl) begin
        n.instr = 0; n.valid = 0;
      end else begin
        n.instr = rom[s.pc[9:2]]; n.pcp4 = seq; n.valid = 1;
      end
    end
    return n;
  endfunction

  // Drive one cycle of inputs, queue the prediction, return just after the edge.
  task automatic step(input logic rst, input logic stl, input logic fl, input logic rv,
                      input logic [31:0] rp, input logic iq, input logic ex);
    @(negedge clk);
    reset = rst; bus.stall = stl; bus.flush = fl; bus.redirect_valid = rv;
    bus.redirect_pc = rp; bus.irq = iq; bus.exc = ex;
    m = ref_next(m, rst, stl, fl, rv, rp, iq, ex);
    exp_q.push_back(m);
    running = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0, 0, 0);
  endtask

  // Monitor: one comparison set per edge.
  always @(posedge clk) begin
    st_t e;
    #1;
    if (running) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        e = exp_q.pop_front();
        check("rom_addr", bus.rom_addr, e.pc);
        check("pc", bus.pc, e.pc);
        check("ifid_instr", bus.ifid_instr, e.instr);
        check("ifid_pc_plus4", bus.ifid_pc_plus4, e.pcp4);
        check("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, e.valid});
        check("epc", bus.epc, e.epc);
        check("epc_we", {31'd0, bus.epc_we}, {31'd0, e.epc_we});
      end
    end
  end

  initial begin
    logic [31:0] exp_epc;
    logic [31:0] tgt;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0800_0003;
    rom[3] = 32'h3C16_4000;
    m = '{pc: 0, instr: 0, pcp4: 0, valid: 0, epc: 0, epc_we: 0};
    reset = 1; bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0;
    bus.redirect_pc = 0; bus.irq = 0; bus.exc = 0;

    // 1: reset fetch
    step(1, 0, 0, 0, 32'd0, 0, 0);
    step(1, 0, 0, 0, 32'd0, 0, 0);
    check("tp1_rom_addr_reset", bus.rom_addr, 32'h8000_0000);
    check("tp1_valid_reset", {31'd0, bus.ifid_valid}, 32'd0);
    idle(1);
    check("tp1_instr", bus.ifid_instr, 32'h0800_0003);
    check("tp1_pcp4", bus.ifid_pc_plus4, 32'h8000_0004);
    check("tp1_pc", bus.pc, 32'h8000_0004);

    // 2: redirect then sequential
    step(0, 0, 0, 1, 32'h8000_000C, 0, 0);
    check("tp2_pc", bus.pc, 32'h8000_000C);
    check("tp2_bubble", {31'd0, bus.ifid_valid}, 32'd0);
    idle(1);
    check("tp2_instr", bus.ifid_instr, 32'h3C16_4000);
    check("tp2_pc_inc", bus.pc, 32'h8000_0010);
    idle(2);

    // 3: user-mode interrupt and return
    step(0, 0, 0, 1, 32'h0000_0178, 0, 0);
    idle(1);
    check("tp3_pc_user", bus.pc, 32'h0000_017C);
    step(0, 0, 0, 0, 32'd0, 1, 0);
    check("tp3_pc_vec", bus.pc, 32'h8000_0004);
    check("tp3_epc", bus.epc, 32'h0000_017C);
    check("tp3_epc_we", {31'd0, bus.epc_we}, 32'd1);
    idle(1);
    check("tp3_epc_we_once", {31'd0, bus.epc_we}, 32'd0);
    idle(2);
    step(0, 0, 0, 1, 32'h0000_017C, 0, 0);
    check("tp3_resume", bus.pc, 32'h0000_017C);

    // 4: masked in kernel, deferred under stall
    step(0, 0, 0, 1, 32'h8000_0010, 0, 0);
    step(0, 0, 0, 0, 32'd0, 1, 0);
    step(0, 0, 0, 0, 32'd0, 1, 0);
    check("tp4_kernel_mask", bus.pc, 32'h8000_0018);
    step(0, 0, 0, 1, 32'h0000_0200, 0, 0);
    step(0, 1, 0, 0, 32'd0, 1, 0);
    step(0, 1, 0, 0, 32'd0, 1, 0);
    check("tp4_stall_hold", bus.pc, 32'h0000_0200);
    check("tp4_stall_no_we", {31'd0, bus.epc_we}, 32'd0);
    step(0, 0, 0, 0, 32'd0, 1, 0);
    check("tp4_deferred_vec", bus.pc, 32'h8000_0004);
    check("tp4_deferred_epc", bus.epc, 32'h0000_0200);

    // 5: stall / flush
    step(0, 0, 0, 1, 32'h0000_0300, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'd0, 0, 0);
    check("tp5_stall_pc", bus.pc, 32'h0000_0308);
    check("tp5_stall_valid", {31'd0, bus.ifid_valid}, 32'd1);
    step(0, 1, 1, 0, 32'd0, 0, 0);
    check("tp5_flush_pc", bus.pc, 32'h0000_0308);
    check("tp5_flush_instr", bus.ifid_instr, 32'd0);

    // 6: priority and wrap
    idle(1);
    exp_epc = m.pcp4;
    step(0, 0, 0, 1, 32'h0000_0440, 1, 1);
    check("tp6_exc_pc", bus.pc, 32'h8000_0008);
    check("tp6_exc_epc", bus.epc, exp_epc);
    step(0, 0, 0, 1, 32'h7FFF_FFFC, 0, 0);
    idle(1);
    check("tp6_wrap_user", bus.pc, 32'h0000_0000);
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(1);
    check("tp6_wrap_kernel", bus.pc, 32'h8000_0000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[31] = 1'b0;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, tgt,
           $urandom_range(0, 9) == 0, $urandom_range(0, 31) == 0);
    end

    running = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 32-bit MIPS core.
- Owns the PC and drives the address of the combinational instruction ROM.
- Captures the returned word into the IF/ID pipeline register.
- Applies the reset, interrupt (0x80000004) and exception (0x80000008) vectors.
- Applies branch/jump redirects and stalls, and produces the EPC for the `$k0` write.
- PC[31] is the kernel bit. It is set in kernel and handler code and cleared in user code. A `jr $k0` sourced from the EPC returns to user mode.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset (ROM word 0: j Main).
- IRQ_VEC, 32'h8000_0004, interrupt vector.
- EXC_VEC, 32'h8000_0008, exception vector.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  32  instruction address; combinationally equal to pc.
- rom_data  in  32  instruction word from ROM; valid in the same cycle as rom_addr.
- stall  in  1  hazard stall; holds pc and IF/ID.
- flush  in  1  squash IF/ID; inserts a bubble.
- redirect_valid  in  1  taken branch/j/jal/jr resolved downstream.
- redirect_pc  in  32  target for redirect_valid.
- irq  in  1  level interrupt request (timer TCON).
- exc  in  1  one-cycle exception request from decode (undefined opcode).
- pc  out  32  current fetch PC.
- ifid_instr  out  32  latched instruction.
- ifid_pc_plus4  out  32  latched PC+4 of ifid_instr.
- ifid_valid  out  1  ifid_instr is a real instruction (0 = bubble).
- epc  out  32  return address for `$k0`.
- epc_we  out  1  one-cycle pulse: register file writes epc into `$k0`.

Behaviour:
- **Reset (synchronous, dominates all inputs, including mid-stall and mid-redirect):**
  - pc=RESET_PC
  - ifid_instr=0 (nop), ifid_pc_plus4=0, ifid_valid=0
  - epc=0, epc_we=0
- **Fetch latency:** rom_addr=pc with zero latency. rom_data is registered into IF/ID at the next edge, so there is 1 cycle from PC to ifid_instr.
- **Sequential increment:** pc_next = {pc[31], pc[30:0]+31'd4}. The kernel bit is preserved. Bits [30:0] wrap modulo 2^31: 0x7FFFFFFC -> 0x00000000, and 0xFFFFFFFC -> 0x80000000.
- **Interrupt enable:** irq_take = irq & ~pc[31] & ~stall. Interrupts are masked in kernel mode. They are deferred while stalled, and irq stays pending as a level.
- **Per-edge priority (highest first):**
  1. reset.
  2. exc: pc<=EXC_VEC; epc<=ifid_pc_plus4; epc_we<=1; IF/ID<=bubble.
  3. irq_take: pc<=IRQ_VEC; epc<=(redirect_valid ? redirect_pc : pc); epc_we<=1; IF/ID<=bubble. The squashed fetch, or the pending redirect target, is resumed on `jr $k0`, so no redirect is lost.
  4. redirect_valid: pc<=redirect_pc, loaded verbatim, so jr may clear pc[31]; IF/ID<=bubble.
  5. stall: pc held; IF/ID held, unless flush=1, which forces a bubble.
  6. otherwise: pc<=pc_next; ifid_instr<=rom_data; ifid_pc_plus4<=pc_next; ifid_valid<=1. If flush=1, IF/ID<=bubble while pc still advances.
- **Bubble:** ifid_instr=0, ifid_valid=0, ifid_pc_plus4 unchanged.
- **Stall interactions:** exc and redirect override stall.
- **epc_we:** high for exactly one cycle after a vector is taken, else 0. epc holds its value between events.
- **Redirect alignment:** redirect_pc[1:0] is not checked. It is passed through, and the ROM ignores addr[1:0].
- **Simultaneous exc and irq:** exc is taken; the irq is masked because pc[31]=1 in the handler.

Test Plan:
1. **Reset fetch:** reset for 2 cycles, then release.
   - During reset: rom_addr=0x80000000, ifid_valid=0.
   - After the first edge out of reset: ifid_instr=0x08000003, ifid_pc_plus4=0x80000004, pc=0x80000004.
2. **Redirect then sequential:** redirect_valid=1 with redirect_pc=0x8000000C for one cycle.
   - Next cycle: pc=0x8000000C, ifid_valid=0.
   - Following cycle: ifid_instr=0x3C164000, then pc increments by 4 per cycle.
3. **User-mode interrupt:** redirect to 0x00000178, then assert irq at pc=0x0000017C.
   - pc=0x80000004, epc=0x0000017C, epc_we pulses once, ifid_valid=0.
   - Later, redirect_pc=epc resumes at 0x0000017C with pc[31]=0.
4. **Masked in kernel, deferred under stall:**
   - irq=1 while pc=0x80000010: no vector; sequential fetch continues.
   - In user mode with stall=1 and irq=1: pc held, no epc_we. When stall drops, the vector is taken at the next edge.
5. **Stall/flush:**
   - stall=1 for 3 cycles: pc and IF/ID constant.
   - stall=1 with flush=1: pc held, ifid_valid=0, ifid_instr=0.
6. **Priority and wrap:**
   - exc=1, irq=1 and redirect_valid=1 in the same cycle: pc=0x80000008, epc=previous ifid_pc_plus4, redirect ignored.
   - Redirect to 0x7FFFFFFC, then one sequential step: pc=0x00000000.
